// File: rtl/alu_sequencer.sv
// Purpose : issues one command at a time to an external combinational ALU, holds the
//           operands stable while the ALU settles, then captures and presents the result.
// Latency : accept edge to rsp_valid high is exactly SETTLE_CYCLES cycles; one command per
//           SETTLE_CYCLES+2 cycles with rsp_ready held high (no same-cycle turnaround).
// Backpressure: rsp_valid/rsp_result/flags hold while rsp_ready is low; cmd_ready stays low
//           until the response handshake completes, so extra cmd_valid pulses are ignored.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_opcode, cmd_op1, cmd_op2        command payload (opcode is passed through, never decoded)
//   Opcode, Operand1, Operand2          registered ALU inputs, held from accept to next accept
//   Result, flagC, flagZ                ALU outputs, sampled at the end of the settle window
//   rsp_valid/rsp_ready                 response handshake
//   rsp_result, rsp_flagC, rsp_flagZ    captured ALU outputs
//   txn_count                           completed transactions, wraps at 16 bits
//
// SETTLE_CYCLES legal range is 1..15 (the settle counter is 4 bits wide).

module alu_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [7:0]  cmd_op1,
    input  logic [7:0]  cmd_op2,
    output logic [3:0]  Opcode,
    output logic [7:0]  Operand1,
    output logic [7:0]  Operand2,
    input  logic [15:0] Result,
    input  logic        flagC,
    input  logic        flagZ,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_flagC,
    output logic        rsp_flagZ,
    output logic [15:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [15:0] txn_q;
    logic        accept;
    logic        settle_done;
    logic        rsp_done;

    // Gated by rst_n so the block never advertises readiness while held in reset,
    // even on the very first reset cycle when the state register may still be unknown.
    assign cmd_ready   = rst_n && (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign settle_done = (state == SETTLE) && (settle_cnt == 4'd0);
    // rsp_valid is only set by the capture edge, so a handshake needs it already high;
    // rsp_ready asserted on the capture edge itself cannot complete one.
    assign rsp_done    = (state == RESP) && rsp_valid && rsp_ready;
    assign txn_count   = txn_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Settle counter: loaded with SETTLE_CYCLES-1 on accept so the capture edge lands
    // exactly SETTLE_CYCLES edges after the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // ALU operand registers: written only on accept, held through every other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Opcode   <= 4'd0;
            Operand1 <= 8'd0;
            Operand2 <= 8'd0;
        end else if (accept) begin
            Opcode   <= cmd_opcode;
            Operand1 <= cmd_op1;
            Operand2 <= cmd_op2;
        end
    end

    // Response capture: result and flags are sampled once and then frozen, so ALU
    // activity during RESP cannot disturb what the consumer sees.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 16'd0;
            rsp_flagC  <= 1'b0;
            rsp_flagZ  <= 1'b0;
        end else if (settle_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= Result;
            rsp_flagC  <= flagC;
            rsp_flagZ  <= flagZ;
        end else if (rsp_done) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Completed-transaction counter, natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_q <= 16'd0;
        end else if (rsp_done) begin
            txn_q <= txn_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_op1;
    logic [7:0]  cmd_op2;
    logic        rsp_ready;
    logic        stub_zero;
    logic [15:0] alt_result;

    int passed;
    int total;

    // SETTLE_CYCLES=2 instance with an adder stub ALU
    logic        cmd_ready2;
    logic [3:0]  opcode2;
    logic [7:0]  operand1_2;
    logic [7:0]  operand2_2;
    logic [15:0] result2;
    logic        flagc2;
    logic        flagz2;
    logic        rsp_valid2;
    logic [15:0] rsp_result2;
    logic        rsp_flagc2;
    logic        rsp_flagz2;
    logic [15:0] txn2;

    logic [15:0] sum2;
    assign sum2    = {8'd0, operand1_2} + {8'd0, operand2_2};
    assign result2 = stub_zero ? 16'd0 : sum2;
    assign flagc2  = result2[8];
    assign flagz2  = (result2 == 16'd0);

    alu_sequencer #(.SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .Opcode(opcode2), .Operand1(operand1_2), .Operand2(operand2_2),
        .Result(result2), .flagC(flagc2), .flagZ(flagz2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result2), .rsp_flagC(rsp_flagc2), .rsp_flagZ(rsp_flagz2),
        .txn_count(txn2)
    );

    // SETTLE_CYCLES=1 and 15 instances for latency measurement, constant ALU outputs
    logic        cmd_ready1, cmd_ready15;
    logic [3:0]  opcode1, opcode15;
    logic [7:0]  op1_1, op1_15, op2_1, op2_15;
    logic        rsp_valid1, rsp_valid15;
    logic [15:0] rsp_result1, rsp_result15;
    logic        rsp_flagc1, rsp_flagc15, rsp_flagz1, rsp_flagz15;
    logic [15:0] txn1, txn15;

    alu_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .Opcode(opcode1), .Operand1(op1_1), .Operand2(op2_1),
        .Result(alt_result), .flagC(1'b1), .flagZ(1'b1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result1), .rsp_flagC(rsp_flagc1), .rsp_flagZ(rsp_flagz1),
        .txn_count(txn1)
    );

    alu_sequencer #(.SETTLE_CYCLES(15)) u15 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready15),
        .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .Opcode(opcode15), .Operand1(op1_15), .Operand2(op2_15),
        .Result(alt_result), .flagC(1'b1), .flagZ(1'b0),
        .rsp_valid(rsp_valid15), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result15), .rsp_flagC(rsp_flagc15), .rsp_flagZ(rsp_flagz15),
        .txn_count(txn15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int lat1;
    int lat2;
    int lat15;

    initial begin
        passed     = 0;
        total      = 0;
        stub_zero  = 1'b0;
        alt_result = 16'hBEEF;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 4'd0;
        cmd_op1    = 8'd0;
        cmd_op2    = 8'd0;
        rsp_ready  = 1'b0;

        // Reset for 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            cmd_valid  = 1'($urandom);
            cmd_opcode = 4'($urandom);
            cmd_op1    = 8'($urandom);
            cmd_op2    = 8'($urandom);
            rsp_ready  = 1'($urandom);
            tick();
        end
        chk("rst_cmd_ready", {31'd0, cmd_ready2}, 32'd0);
        chk("rst_opcode",    {28'd0, opcode2}, 32'd0);
        chk("rst_operand1",  {24'd0, operand1_2}, 32'd0);
        chk("rst_operand2",  {24'd0, operand2_2}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid2}, 32'd0);
        chk("rst_rsp_result", {16'd0, rsp_result2}, 32'd0);
        chk("rst_flags",     {30'd0, rsp_flagc2, rsp_flagz2}, 32'd0);
        chk("rst_txn",       {16'd0, txn2}, 32'd0);

        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready2}, 32'd1);

        // Basic transaction: 123 + 100 = 223
        cmd_valid  = 1'b1;
        cmd_opcode = 4'b0001;
        cmd_op1    = 8'd123;
        cmd_op2    = 8'd100;
        rsp_ready  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("basic_opcode",   {28'd0, opcode2}, 32'd1);
        chk("basic_operand1", {24'd0, operand1_2}, 32'd123);
        chk("basic_operand2", {24'd0, operand2_2}, 32'd100);
        chk("basic_busy",     {31'd0, cmd_ready2}, 32'd0);
        tick();
        chk("basic_valid_n1", {31'd0, rsp_valid2}, 32'd0);
        tick();
        chk("basic_valid_n2", {31'd0, rsp_valid2}, 32'd1);
        chk("basic_result",   {16'd0, rsp_result2}, 32'd223);
        chk("basic_flagz",    {31'd0, rsp_flagz2}, 32'd0);
        chk("basic_flagc",    {31'd0, rsp_flagc2}, 32'd0);
        chk("basic_txn_before_hs", {16'd0, txn2}, 32'd0);
        tick();
        chk("basic_hs_valid", {31'd0, rsp_valid2}, 32'd0);
        chk("basic_txn",      {16'd0, txn2}, 32'd1);
        chk("basic_ready",    {31'd0, cmd_ready2}, 32'd1);
        chk("basic_result_kept", {16'd0, rsp_result2}, 32'd223);

        // Backpressure: 222 + 10 = 232, ALU result later forced to 0
        rsp_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = 4'hA;
        cmd_op1    = 8'd222;
        cmd_op2    = 8'd10;
        tick();
        // keep requesting with different payload; must be ignored
        cmd_op1 = 8'd5;
        cmd_op2 = 8'd6;
        cmd_opcode = 4'h3;
        tick();
        tick();
        chk("bp_valid",  {31'd0, rsp_valid2}, 32'd1);
        chk("bp_result", {16'd0, rsp_result2}, 32'd232);
        stub_zero = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_result_held", {16'd0, rsp_result2}, 32'd232);
        chk("bp_flagz_held",  {31'd0, rsp_flagz2}, 32'd0);
        chk("bp_valid_held",  {31'd0, rsp_valid2}, 32'd1);
        chk("bp_cmd_ready",   {31'd0, cmd_ready2}, 32'd0);
        chk("bp_operand1",    {24'd0, operand1_2}, 32'd222);
        chk("bp_opcode",      {28'd0, opcode2}, 32'hA);
        chk("bp_txn",         {16'd0, txn2}, 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        stub_zero = 1'b0;
        chk("bp_hs_valid", {31'd0, rsp_valid2}, 32'd0);
        chk("bp_hs_txn",   {16'd0, txn2}, 32'd2);
        chk("bp_hs_ready", {31'd0, cmd_ready2}, 32'd1);
        chk("bp_operand1_idle", {24'd0, operand1_2}, 32'd222);

        // Reset in the middle of SETTLE
        cmd_valid = 1'b1;
        cmd_op1   = 8'd50;
        cmd_op2   = 8'd60;
        tick();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        chk("mid_rst_valid",    {31'd0, rsp_valid2}, 32'd0);
        chk("mid_rst_operand1", {24'd0, operand1_2}, 32'd0);
        chk("mid_rst_txn",      {16'd0, txn2}, 32'd0);
        chk("mid_rst_ready",    {31'd0, cmd_ready2}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_ready_after", {31'd0, cmd_ready2}, 32'd1);
        tick();
        tick();
        tick();
        chk("mid_rst_discarded", {31'd0, rsp_valid2}, 32'd0);

        // Counter wrap: preload 16'hFFFF then complete one transaction
        force u2.txn_q = 16'hFFFF;
        tick();
        release u2.txn_q;
        cmd_valid = 1'b1;
        cmd_op1   = 8'd1;
        cmd_op2   = 8'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("wrap_result", {16'd0, rsp_result2}, 32'd3);
        tick();
        chk("wrap_txn", {16'd0, txn2}, 32'd0);

        // Latency for SETTLE_CYCLES = 1, 2, 15
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b1;
        cmd_op1   = 8'd7;
        cmd_op2   = 8'd8;
        tick();
        cmd_valid = 1'b0;
        lat1  = 0;
        lat2  = 0;
        lat15 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rsp_valid1  && lat1  == 0) lat1  = k;
            if (rsp_valid2  && lat2  == 0) lat2  = k;
            if (rsp_valid15 && lat15 == 0) lat15 = k;
        end
        chk("lat_s1",  lat1,  32'd1);
        chk("lat_s2",  lat2,  32'd2);
        chk("lat_s15", lat15, 32'd15);
        chk("s15_result", {16'd0, rsp_result15}, 32'hBEEF);
        chk("s15_flags",  {30'd0, rsp_flagc15, rsp_flagz15}, 32'd2);
        chk("s1_flags",   {30'd0, rsp_flagc1, rsp_flagz1}, 32'd3);
        chk("s2_result",  {16'd0, rsp_result2}, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
